// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell reused over WIDTH cycles.
// Optional early exit on all-zero remaining bits: define SERIAL_ADD_EARLY_TERM_EN.

module serial_add_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ofl,
  output logic [1:0]       dbg_state
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  // Handshake: start is taken on any edge where the FSM is IDLE or DONE; operands
  // and sub are captured on that same edge. done pulses for one cycle and S/Cout/Ofl
  // are valid from that cycle until the next completion.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fa_s, fa_co;
  logic             last_bit;
  logic             early_exit;

  serial_add_fa u_fa (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_ADD_EARLY_TERM_EN
  // Never on the MSB edge, so a genuine MSB overflow is still reported.
  assign early_exit = ~last_bit && ~fa_co &&
                      (opa_q[WIDTH-1:1] == '0) && (opb_q[WIDTH-1:1] == '0);
`else
  assign early_exit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          opa_d   = A;
          opb_d   = sub ? ~B : B;
          carry_d = sub;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[cnt_q] = fa_s;
        carry_d      = fa_co;
        opa_d        = {1'b0, opa_q[WIDTH-1:1]};
        opb_d        = {1'b0, opb_q[WIDTH-1:1]};
        cnt_d        = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = ST_DONE;
          s_d     = sum_d;
          cout_d  = fa_co;
          cmsb_d  = carry_q;
        end else if (early_exit) begin
          state_d = ST_DONE;
          s_d     = sum_d;
          cout_d  = 1'b0;
          cmsb_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Overflow comes from two flops that only move together on DONE entry.
  assign Ofl       = cmsb_q ^ cout_q;
  assign S         = s_q;
  assign Cout      = cout_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract sequencer.
- Time-shares exactly one instance of the codebase's single-bit full-adder cell (inputs A, B, Cin; outputs S, Cout) across WIDTH cycles to produce a WIDTH-bit sum or difference.
- Serves as the low-area arithmetic unit for multi-cycle ops (address/offset calc, divide-step helper) beside the pipelined ALU.
- Handles operand capture, carry sequencing, bit counting, flag generation and the start/done handshake.

Parameters:
- WIDTH, 16, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = A+B, 1 = A-B; captured with start.
- A  input  WIDTH  operand A; captured with start.
- B  input  WIDTH  operand B; captured with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; S/Cout/Ofl valid from this cycle onward.
- S  output  WIDTH  result register; holds the last completed result.
- Cout  output  1  carry out of the MSB. For sub, 1 = no borrow.
- Ofl  output  1  two's-complement overflow = carry-in(MSB) XOR carry-out(MSB).

Behaviour:
- Reset (async, no clock needed):
  - state = IDLE; busy = 0, done = 0.
  - S = 0, Cout = 0, Ofl = 0.
  - Bit counter, operand shift registers, working sum and carry flop all cleared.
- FSM states IDLE, RUN, DONE.
  - IDLE: start = 1 at edge E0 loads:
    - opA shift register <- A.
    - opB shift register <- (sub ? ~B : B).
    - carry flop <- sub.
    - working sum <- 0; counter <- 0.
    - Next state RUN.
    - start = 0 keeps the FSM in IDLE.
  - RUN: each edge feeds opA[0], opB[0] and the carry flop to the adder cell.
    - Writes the sum bit into working sum[counter].
    - Carry flop <- cell Cout.
    - opA and opB shift right by one, zero-filled.
    - counter increments.
    - Edge E(i+1) processes bit i. When the edge processing bit WIDTH-1 occurs (E(WIDTH)), the next state is DONE.
  - DONE: entered at E(WIDTH).
    - At the same edge, S <- working sum and Cout <- final carry.
    - Ofl <- carry into bit WIDTH-1 XOR final carry; the carry into the MSB is held in a dedicated flop captured while processing bit WIDTH-1.
    - done = 1 for exactly this cycle.
    - start = 1 here is accepted exactly as in IDLE (back-to-back); otherwise the next state is IDLE.
- Latency: done is high in the cycle between E(WIDTH) and E(WIDTH+1). busy is high for exactly WIDTH cycles. Throughput is one op per WIDTH+1 cycles.
- start while busy is ignored; operand and sub changes during RUN have no effect.
- S, Cout and Ofl change only on entry to DONE (or reset). They are stable during RUN and hold indefinitely in IDLE.
- busy and done are registered state decodes, never both high.
- Reset mid-RUN aborts the op; no done is produced. The first start after reset release behaves normally.
- Wrap-around: the carry out of the MSB is reported in Cout only, never wrapped into S.

Optional Feature:
- Macro: SERIAL_ADD_EARLY_TERM_EN.
- Defined: in RUN, if after the current bit the remaining opA and opB bits are all zero and the new carry is 0, the next state is DONE at that edge.
  - Unwritten sum bits stay 0.
  - Cout = 0 and Ofl = 0 for an early-terminated op.
  - At least one bit is always processed, so minimum busy = 1 cycle.
- Not defined: always exactly WIDTH bit-cycles; no early-exit logic is synthesized.

Test Plan:
- WIDTH=16, add A=0x1234, B=0x4321 -> done exactly in the cycle after E16; S=0x5555, Cout=0, Ofl=0; busy high for 16 cycles.
- Add A=0x7FFF, B=0x0001 -> S=0x8000, Ofl=1, Cout=0. Add A=0xFFFF, B=0x0001 -> S=0x0000, Cout=1, Ofl=0.
- Sub A=0x0005, B=0x0007 -> S=0xFFFE, Cout=0, Ofl=0. Sub A=0x8000, B=0x0001 -> S=0x7FFF, Cout=1, Ofl=1.
- Start during RUN with different operands -> ignored, first result unchanged. Start held in the DONE cycle with A=1, B=1 -> busy next cycle, S=0x0002 after 16 more cycles.
- Assert rst after 5 bit-cycles, between clock edges -> busy, done, S, Cout and Ofl all 0 immediately; no done pulse; the next op completes correctly.
- Macro defined, add A=0x0003, B=0x0001 -> done after 3 bit-cycles, S=0x0004, Cout=0. Macro undefined, same op -> 16 bit-cycles, same S.
